// File: rtl/cam_search.sv
// cam_search: register-based content-addressable memory with a sequential
// linear search. Keys are appended in order; a search walks the valid
// entries from address 0 upward, one entry per cycle, and reports the
// lowest matching address.
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   cam_start       - one-cycle search request (ignored unless idle)
//   search_key      - key to search for, captured with an accepted cam_start
//   cam_write_en    - one-cycle request to append write_key
//   write_key       - key to store
//   cam_clear       - one-cycle request to invalidate all entries
//   match           - result of the last completed search (1 = hit)
//   match_addr      - address of the hit entry, 0 on a miss
//   search_done     - one-cycle pulse when match/match_addr are fresh
//   busy            - a search is scanning entries
//   max_add         - highest valid address (entry_count-1), 0 when empty
//   entry_count     - number of valid entries, 0..16
//   full, empty     - entry_count == 16 / entry_count == 0
//   write_err       - one-cycle pulse after a rejected write or clear
module cam_search #(
  parameter int unsigned KEY_W = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cam_start,
  input  logic [KEY_W-1:0] search_key,
  input  logic             cam_write_en,
  input  logic [KEY_W-1:0] write_key,
  input  logic             cam_clear,
  output logic             match,
  output logic [3:0]       match_addr,
  output logic             search_done,
  output logic             busy,
  output logic [3:0]       max_add,
  output logic [4:0]       entry_count,
  output logic             full,
  output logic             empty,
  output logic             write_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state, state_next;
  logic [3:0]       index, index_next;
  logic [KEY_W-1:0] key_q;
  logic [KEY_W-1:0] entries [DEPTH];

  logic             clr_accept;
  logic             wr_accept;
  logic             start_accept;
  logic             err_next;
  logic [4:0]       count_next;
  logic             entry_hit;
  logic             res_load;
  logic             res_match;
  logic [3:0]       res_addr;

  // Status flags derived purely from the entry count.
  assign empty   = (entry_count == 5'd0);
  assign full    = (entry_count == 5'd16);
  // For a full table the 4-bit subtraction wraps 0-1 to 15, as required.
  assign max_add = empty ? '0 : (entry_count[3:0] - 4'd1);
  assign busy    = (state == SCAN);

  // Storage updates. A clear takes precedence over a simultaneous write;
  // neither is allowed while a scan is reading the table.
  always_comb begin
    clr_accept   = cam_clear && !busy;
    wr_accept    = cam_write_en && !busy && !full && !cam_clear;
    start_accept = cam_start && (state == IDLE);
    err_next     = (cam_clear && busy) ||
                   (cam_write_en && !cam_clear && (busy || full));
    if (clr_accept)
      count_next = '0;
    else if (wr_accept)
      count_next = entry_count + 5'd1;
    else
      count_next = entry_count;
  end

  // Entry compare for the current scan position; addresses beyond the
  // valid range never match even if they hold stale data.
  assign entry_hit = (entries[index] == key_q) && ({1'b0, index} < entry_count);

  always_comb begin
    state_next = state;
    index_next = index;
    res_load   = 1'b0;
    res_match  = 1'b0;
    res_addr   = '0;
    unique case (state)
      IDLE: begin
        if (start_accept) begin
          index_next = '0;
          // The emptiness test uses the count after any same-cycle
          // write/clear so a write issued with cam_start is searched.
          if (count_next == 5'd0) begin
            state_next = DONE;
            res_load   = 1'b1;
          end else begin
            state_next = SCAN;
          end
        end
      end
      SCAN: begin
        if (entry_hit) begin
          state_next = DONE;
          res_load   = 1'b1;
          res_match  = 1'b1;
          res_addr   = index;
        end else if (index == max_add) begin
          state_next = DONE;
          res_load   = 1'b1;
        end else begin
          index_next = index + 4'd1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      index       <= '0;
      entry_count <= '0;
      match       <= 1'b0;
      match_addr  <= '0;
      search_done <= 1'b0;
      write_err   <= 1'b0;
    end else begin
      state       <= state_next;
      index       <= index_next;
      entry_count <= count_next;
      write_err   <= err_next;
      // Registered pulse lines up with the single DONE cycle.
      search_done <= (state_next == DONE);
      if (res_load) begin
        match      <= res_match;
        match_addr <= res_addr;
      end
    end
  end

  // Search key and table contents carry no reset.
  always_ff @(posedge clk) begin
    if (start_accept)
      key_q <= search_key;
    if (wr_accept)
      entries[entry_count[3:0]] <= write_key;
  end

endmodule
